// File: rtl/tristate_tx_driver_pkg.sv
// Shared definitions for the tristate transmit driver and its sub-modules.
//
// Contents:
//   DEFAULT_WIDTH - default data word width, shared with the buffer bench
//   DEFAULT_TURN  - default turnaround length in cycles
//   state_t       - framing state encoding (3-bit)
package tristate_tx_driver_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_TURN  = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_SHIFT = 3'd2,
    ST_STOP  = 3'd3,
    ST_TURN  = 3'd4
  } state_t;

endpackage

// File: rtl/tristate_tx_driver_down_counter.sv
// Loadable decrementing counter with a zero flag. It is used once to count
// data bits and once to count turnaround cycles.
//
// Ports:
//   clk, rst    - clock and asynchronous active-high reset
//   load        - load load_value (takes priority over dec)
//   load_value  - value to load
//   dec         - decrement by one; holds at zero rather than wrapping
//   zero        - count is zero
module down_counter
  import tristate_tx_driver_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // Load wins over decrement. The counter saturates at zero so that a stray
  // decrement can never wrap it into a long, bogus count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/tristate_tx_driver.sv
// Serializing driver that feeds the data and enable inputs of a tristate
// output buffer. A word accepted over valid/ready is framed as a start bit
// (0), then the data MSB-first, then a stop bit (1). After the frame, en is
// held low for TURN cycles so that another driver can take the line.
//
// Ports:
//   clk, rst   - clock and asynchronous active-high reset
//   din        - parallel word to transmit
//   din_valid  - din is presented
//   din_ready  - driver is idle and accepts a word
//   d, en      - registered data and enable to the tristate buffer
//   busy       - a frame or turnaround is in progress
//   done       - one-cycle pulse in the cycle after the stop bit
module tristate_tx_driver
  import tristate_tx_driver_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int TURN  = DEFAULT_TURN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             d,
  output logic             en,
  output logic             busy,
  output logic             done
);

  localparam int BIT_CW  = $clog2(WIDTH) + 1;
  localparam int TURN_CW = $clog2(TURN + 1) + 1;
  localparam logic [BIT_CW-1:0]  BIT_LOAD  = BIT_CW'(WIDTH - 1);
  localparam logic [TURN_CW-1:0] TURN_LOAD = TURN_CW'((TURN > 0) ? TURN - 1 : 0);

  state_t           state, next_state;
  logic [WIDTH-1:0] shreg, shreg_next;
  logic             bit_load, bit_dec, bit_zero;
  logic             turn_load, turn_dec, turn_zero;
  logic             d_next, en_next, done_next;

  down_counter #(.W(BIT_CW)) u_bit_cnt (
    .clk        (clk),
    .rst        (rst),
    .load       (bit_load),
    .load_value (BIT_LOAD),
    .dec        (bit_dec),
    .zero       (bit_zero)
  );

  down_counter #(.W(TURN_CW)) u_turn_cnt (
    .clk        (clk),
    .rst        (rst),
    .load       (turn_load),
    .load_value (TURN_LOAD),
    .dec        (turn_dec),
    .zero       (turn_zero)
  );

  // State, shift register and line outputs are all registered. d/en/done are
  // computed from the next state so that they change on the same edge as the
  // state, and the buffer never sees a combinational glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      shreg <= '0;
      d     <= 1'b0;
      en    <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      shreg <= shreg_next;
      d     <= d_next;
      en    <= en_next;
      done  <= done_next;
    end
  end

  // Next-state logic. The shift register is loaded only on accept, so din
  // changes during a frame cannot affect the transmitted word. The shift
  // happens on the edges that leave a SHIFT cycle, which makes the post-shift
  // MSB the next data bit to put on the line.
  always_comb begin
    next_state = state;
    shreg_next = shreg;
    bit_load   = 1'b0;
    bit_dec    = 1'b0;
    turn_load  = 1'b0;
    turn_dec   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (din_valid) begin
          shreg_next = din;
          next_state = ST_START;
        end
      end
      ST_START: begin
        bit_load   = 1'b1;
        next_state = ST_SHIFT;
      end
      ST_SHIFT: begin
        shreg_next = shreg << 1;
        if (bit_zero) begin
          next_state = ST_STOP;
        end else begin
          bit_dec = 1'b1;
        end
      end
      ST_STOP: begin
        if (TURN > 0) begin
          turn_load  = 1'b1;
          next_state = ST_TURN;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_TURN: begin
        if (turn_zero) begin
          next_state = ST_IDLE;
        end else begin
          turn_dec = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Line values that take effect with the next state. The start bit and the
  // idle/turnaround line are 0, and the stop bit is 1.
  always_comb begin
    en_next   = (next_state == ST_START) || (next_state == ST_SHIFT) ||
                (next_state == ST_STOP);
    d_next    = 1'b0;
    done_next = (state == ST_STOP);
    if (next_state == ST_SHIFT) begin
      d_next = shreg_next[WIDTH-1];
    end else if (next_state == ST_STOP) begin
      d_next = 1'b1;
    end
  end

  assign din_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_tristate_tx_driver.sv
// Self-checking bench for tristate_tx_driver. Instance A uses WIDTH=8 and
// TURN=2, and instance B uses WIDTH=1 and TURN=0. Single frames are driven
// from a vector table. Reset, back-to-back and minimal-width cases are
// written out by hand.
module tb_tristate_tx_driver;
  import tristate_tx_driver_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       din_valid, din_ready, d, en, busy, done;
  logic [0:0] din_b;
  logic       din_valid_b, din_ready_b, d_b, en_b, busy_b, done_b;

  int pass_count  = 0;
  int check_count = 0;

  always #5 clk = ~clk;

  tristate_tx_driver #(.WIDTH(8), .TURN(2)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .d         (d),
    .en        (en),
    .busy      (busy),
    .done      (done)
  );

  tristate_tx_driver #(.WIDTH(1), .TURN(0)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .din       (din_b),
    .din_valid (din_valid_b),
    .din_ready (din_ready_b),
    .d         (d_b),
    .en        (en_b),
    .busy      (busy_b),
    .done      (done_b)
  );

  typedef struct {
    logic [7:0] word;
    logic       disturb;
    logic [9:0] exp_d;
  } vec_t;

  vec_t vecs [4];

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic wait_ready_a();
    int n = 0;
    @(negedge clk);
    while (!din_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!din_ready) check_output("ready_timeout_a", 32'(din_ready), 32'd1);
  endtask

  // Sends one word on instance A and records 13 cycles after the accept edge:
  // 10 framed bits, 2 turnaround cycles and the first idle cycle.
  task automatic apply_stimulus(input logic [7:0] word, input logic disturb,
                                input logic [9:0] exp_d, input string tag);
    logic [31:0] d_seq, en_mask, done_mask, ready_mask;
    d_seq = '0; en_mask = '0; done_mask = '0; ready_mask = '0;
    wait_ready_a();
    din       = word;
    din_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    din_valid = 1'b0;
    for (int c = 0; c < 13; c++) begin
      en_mask[c]    = en;
      done_mask[c]  = done;
      ready_mask[c] = din_ready;
      if (c < 10) d_seq[9-c] = d;
      if (disturb && c == 3) din = {word[3:0], word[7:4]};
      if (c < 12) @(negedge clk);
    end
    check_output({tag, "_d"},     d_seq,      32'(exp_d));
    check_output({tag, "_en"},    en_mask,    32'h0000_03FF);
    check_output({tag, "_done"},  done_mask,  32'h0000_0400);
    check_output({tag, "_ready"}, ready_mask, 32'h0000_1000);
  endtask

  initial begin
    logic [31:0] en_all, d_all, done_all, mask_b;
    logic [31:0] en_bm, d_bm, done_bm, ready_bm;
    int n;

    vecs[0] = '{word: 8'hA5, disturb: 1'b0, exp_d: 10'b0_10100101_1};
    vecs[1] = '{word: 8'hC3, disturb: 1'b1, exp_d: 10'b0_11000011_1};
    vecs[2] = '{word: 8'h5A, disturb: 1'b0, exp_d: 10'b0_01011010_1};
    vecs[3] = '{word: 8'h01, disturb: 1'b0, exp_d: 10'b0_00000001_1};

    rst = 1'b1; din = '0; din_valid = 1'b0; din_b = '0; din_valid_b = 1'b0;
    #1;
    check_output("rst_en",    32'(en),        32'd0);
    check_output("rst_d",     32'(d),         32'd0);
    check_output("rst_done",  32'(done),      32'd0);
    check_output("rst_busy",  32'(busy),      32'd0);
    check_output("rst_ready", 32'(din_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++)
      apply_stimulus(vecs[i].word, vecs[i].disturb, vecs[i].exp_d,
                     $sformatf("vec%0d", i));

    // Reset in the middle of SHIFT clears the outputs without a clock edge.
    wait_ready_a();
    din = 8'hFF; din_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    din_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_output("pre_rst_en", 32'(en), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_output("mid_rst_en",    32'(en),        32'd0);
    check_output("mid_rst_d",     32'(d),         32'd0);
    check_output("mid_rst_busy",  32'(busy),      32'd0);
    check_output("mid_rst_ready", 32'(din_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    apply_stimulus(8'hA5, 1'b0, 10'b0_10100101_1, "post_rst");

    // Back-to-back frames with din_valid held high: FF then 00.
    wait_ready_a();
    en_all = '0; d_all = '0; done_all = '0;
    din = 8'hFF; din_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    din = 8'h00;
    for (int c = 0; c < 23; c++) begin
      en_all[c]   = en;
      d_all[c]    = d;
      done_all[c] = done;
      if (c == 13) din_valid = 1'b0;
      if (c < 22) @(negedge clk);
    end
    check_output("b2b_en",   en_all,   32'h007F_E3FF);
    check_output("b2b_d",    d_all,    32'h0040_03FE);
    check_output("b2b_done", done_all, 32'h0000_0400);

    // WIDTH=1, TURN=0: start, one data bit, stop, then directly IDLE.
    n = 0;
    @(negedge clk);
    while (!din_ready_b && n < 40) begin
      @(negedge clk);
      n++;
    end
    en_bm = '0; d_bm = '0; done_bm = '0; ready_bm = '0;
    din_b = 1'b1; din_valid_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    din_valid_b = 1'b0;
    for (int c = 0; c < 5; c++) begin
      en_bm[c]    = en_b;
      d_bm[c]     = d_b;
      done_bm[c]  = done_b;
      ready_bm[c] = din_ready_b;
      if (c < 4) @(negedge clk);
    end
    mask_b = 32'h0000_0007;
    check_output("w1_en",    en_bm,    mask_b);
    check_output("w1_d",     d_bm,     32'h0000_0006);
    check_output("w1_done",  done_bm,  32'h0000_0008);
    check_output("w1_ready", ready_bm, 32'h0000_0018);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
